// File: rtl/nibble_serial_cla_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_cla_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/nibble_serial_cla_adder_cla4.sv
// 4-bit carry-lookahead adder slice used as the digit datapath of the serial adder.
module four_bit_CLA_adder_verilog (
  input  logic [3:0] i_A,
  input  logic [3:0] i_B,
  input  logic       i_Cin,
  output logic [3:0] o_Sum,
  output logic       o_Cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = i_A ^ i_B;
  assign w_g = i_A & i_B;

  // Flattened lookahead terms; no carry ripples through earlier stages.
  assign w_c[0] = i_Cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_Cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_Cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_Cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_Cin);

  assign o_Sum  = w_p ^ w_c[3:0];
  assign o_Cout = w_c[4];

endmodule

// File: rtl/nibble_serial_cla_adder.sv
// Digit-serial WIDTH-bit adder/subtractor: one nibble per cycle through a single 4-bit CLA,
// carry chained through a register, result offered on a valid/ready handshake.
module nibble_serial_cla_adder
  import nibble_serial_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout,
  output logic             o_Ovf
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IdxW    = $clog2(NIBBLES);

  state_e              r_state;
  state_e              w_state_d;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic                r_a_msb;
  logic                r_b_msb;
  logic                r_cout;
  logic                r_ovf;
  logic [IdxW-1:0]     r_idx;
  logic [NIBBLE_W-1:0] w_nib_sum;
  logic                w_nib_cout;
  logic                w_last;

  four_bit_CLA_adder_verilog u_cla (
    .i_A    (r_a[NIBBLE_W-1:0]),
    .i_B    (r_b[NIBBLE_W-1:0]),
    .i_Cin  (r_carry),
    .o_Sum  (w_nib_sum),
    .o_Cout (w_nib_cout)
  );

  assign w_last = (r_idx == IdxW'(NIBBLES - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_valid) w_state_d = StRun;
      StRun:   if (w_last)  w_state_d = StDone;
      StDone:  if (i_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StIdle: begin
          if (i_valid) begin
            // Subtract as A + ~B + 1; the +1 rides in on the initial carry.
            r_a     <= i_A;
            r_b     <= i_sub ? ~i_B : i_B;
            r_carry <= i_sub | i_Cin;
            r_a_msb <= i_A[WIDTH-1];
            r_b_msb <= i_sub ^ i_B[WIDTH-1];
            r_idx   <= '0;
          end
        end
        StRun: begin
          r_sum   <= {w_nib_sum, r_sum[WIDTH-1:NIBBLE_W]};
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_carry <= w_nib_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_nib_cout;
            r_ovf  <= (r_a_msb == r_b_msb) && (w_nib_sum[NIBBLE_W-1] != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (r_state == StIdle);
  assign o_valid = (r_state == StDone);
  assign o_Sum   = r_sum;
  assign o_Cout  = r_cout;
  assign o_Ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_cla_adder.sv
// Self-checking bench for nibble_serial_cla_adder (WIDTH=16) against an integer reference model.
module tb_nibble_serial_cla_adder;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_A;
  logic [15:0] i_B;
  logic        i_Cin;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_Sum;
  logic        o_Cout;
  logic        o_Ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_cla_adder #(.WIDTH(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_A     (i_A),
    .i_B     (i_B),
    .i_Cin   (i_Cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_Sum   (o_Sum),
    .o_Cout  (o_Cout),
    .o_Ovf   (o_Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, overflow as signed range violation.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, output logic [15:0] s, output logic co,
                       output logic ov);
    int ua, ub, ur, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      co = (ur > 65535);
    end
    s  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input int hold, input bit junk);
    logic [15:0] es;
    logic        ec, eo;
    int          n;
    model(a, b, cin, sub, es, ec, eo);
    n = 0;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    i_valid = 1'b1;
    i_A = a;
    i_B = b;
    i_Cin = cin;
    i_sub = sub;
    i_ready = 1'b0;
    tick();
    if (junk) begin
      i_A = 16'($urandom);
      i_B = 16'($urandom);
      i_sub = 1'($urandom);
    end else begin
      i_valid = 1'b0;
    end
    n = 0;
    while (!o_valid && n < 20) begin
      if (junk) chk({tag, "_busy"}, 32'(o_ready), 32'd0);
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(o_Sum), 32'(es));
    chk({tag, "_cout"}, 32'(o_Cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(o_Ovf), 32'(eo));
    repeat (hold) begin
      tick();
      chk({tag, "_hold_v"}, 32'(o_valid), 32'd1);
      chk({tag, "_hold_s"}, {15'd0, o_Cout, o_Sum}, {15'd0, ec, es});
      if (junk) chk({tag, "_hold_rdy"}, 32'(o_ready), 32'd0);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    chk({tag, "_vdrop"}, 32'(o_valid), 32'd0);
    chk({tag, "_idle"}, 32'(o_ready), 32'd1);
    i_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] qa[$], qb[$];
    logic        qc[$], qs[$];
    logic [15:0] es;
    logic        ec, eo;
    int          acc_cyc[3];
    int          n_acc, n_res;
    bit          acc_now;

    rst_n = 1'b0;
    i_valid = 1'b0;
    i_A = '0;
    i_B = '0;
    i_Cin = 1'b0;
    i_sub = 1'b0;
    i_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sum", 32'(o_Sum), 32'd0);
    chk("rst_cout", 32'(o_Cout), 32'd0);
    chk("rst_ovf", 32'(o_Ovf), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    rst_n = 1'b1;

    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op("a_minus_a", 16'hA5C3, 16'hA5C3, 1'b0, 1'b1, 0, 1'b0);
    run_op("cin_add", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op("bp_junk", 16'h4321, 16'h8765, 1'b1, 1'b0, 5, 1'b1);

    // Abort mid-run with a handshake attempt held during reset.
    i_valid = 1'b1;
    i_A = 16'h1357;
    i_B = 16'h2468;
    i_sub = 1'b0;
    i_Cin = 1'b0;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    i_valid = 1'b1;
    tick();
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_sum", 32'(o_Sum), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    rst_n = 1'b1;
    i_valid = 1'b0;
    run_op("post_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    // Back-to-back with both handshakes held high.
    for (int k = 0; k < 3; k++) begin
      qa.push_back(16'($urandom));
      qb.push_back(16'($urandom));
      qc.push_back(1'($urandom));
      qs.push_back(1'($urandom));
    end
    n_acc = 0;
    n_res = 0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_A = qa[0];
    i_B = qb[0];
    i_Cin = qc[0];
    i_sub = qs[0];
    for (int cyc = 0; cyc < 40 && n_res < 3; cyc++) begin
      if (o_valid) begin
        if (n_res < n_acc) begin
          model(qa[n_res], qb[n_res], qc[n_res], qs[n_res], es, ec, eo);
          chk("b2b_res", {14'd0, o_Ovf, o_Cout, o_Sum}, {14'd0, eo, ec, es});
        end else begin
          chk("b2b_spurious", 32'(o_valid), 32'd0);
        end
        n_res++;
      end
      acc_now = o_ready && (n_acc < 3);
      if (acc_now) acc_cyc[n_acc] = cyc;
      tick();
      if (acc_now) begin
        n_acc++;
        if (n_acc < 3) begin
          i_A = qa[n_acc];
          i_B = qb[n_acc];
          i_Cin = qc[n_acc];
          i_sub = qs[n_acc];
        end else begin
          i_valid = 1'b0;
        end
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("b2b_count", 32'(n_res), 32'd3);
    chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

    for (int k = 0; k < 20; k++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
